// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: FSM state encoding,
// default hold limit and a small one-hot helper.
package rr_arbiter8_pkg;

    // Arbiter ownership state. IDLE: nobody owns the resource. OWN: the
    // requester at sel owns it this cycle.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    // Number of requesters sharing the resource.
    localparam int N_REQ = 8;

    // Default maximum consecutive cycles one requester may hold the grant
    // while others are waiting. Legal range 1..8.
    localparam int HOLD_MAX_DEFAULT = 4;

    // One-hot mask for a 3-bit requester index.
    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        logic [7:0] v;
        v = 8'h00;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// Requester-side bundle of the round-robin arbiter.
//
// Handshake: req[i] is a level. Requester i raises it and keeps it high until
// grant[i] is seen, then keeps it high for as long as it wants the resource.
// grant[i] high in a cycle means requester i owns the resource in that cycle.
// Dropping req[i] releases (or, before grant, forfeits); the grant follows one
// cycle later. There is no separate ready; grant is the acceptance.
interface rr_arbiter8_if;
    import rr_arbiter8_pkg::*;

    logic [7:0] req;      // level request per requester
    logic [7:0] grant;    // one-hot grant, zero when idle
    logic [2:0] sel;      // index of current owner (demux select)
    logic       busy;     // resource owned this cycle (demux input)
    logic [3:0] hold_cnt; // cycles current owner has held, minus one
    state_t     state;    // FSM state, exposed for debug and checkers

    // Requester side drives requests and observes the arbiter.
    modport master (
        output req,
        input  grant,
        input  sel,
        input  busy,
        input  hold_cnt,
        input  state
    );

    // Arbiter side.
    modport slave (
        input  req,
        output grant,
        output sel,
        output busy,
        output hold_cnt,
        output state
    );

endinterface

// File: rtl/DMux8Way.sv
// 1-to-8 demultiplexer: routes i_in to output bit i_sel, all others zero.
module DMux8Way (
    input  logic       i_in,
    input  logic [2:0] i_sel,
    output logic [7:0] o_out
);

    // Route the single input onto the selected output line.
    always_comb begin
        o_out        = 8'h00;
        o_out[i_sel] = i_in;
    end

endmodule

// File: rtl/rr_pick8.sv
// Rotating priority encoder: finds the first asserted request scanning
// start, start+1, ..., start+7 (mod 8). When exclude_en is set the index
// exclude is never chosen, which ranks the current owner behind everyone.
module rr_pick8 (
    input  logic [7:0] i_req,
    input  logic [2:0] i_start,
    input  logic       i_exclude_en,
    input  logic [2:0] i_exclude,
    output logic       o_found,
    output logic [2:0] o_idx
);

    logic [7:0] w_req_masked;
    logic [2:0] w_cand;

    // Remove the excluded requester from consideration.
    always_comb begin
        w_req_masked = i_req;
        if (i_exclude_en) begin
            w_req_masked[i_exclude] = 1'b0;
        end
    end

    // Scan in rotating order and keep the first hit.
    always_comb begin
        o_found = 1'b0;
        o_idx   = 3'd0;
        w_cand  = 3'd0;
        for (int k = 0; k < 8; k++) begin
            w_cand = i_start + 3'(k);
            if (!o_found && w_req_masked[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for one 8-way demultiplexed resource. Holds the
// ownership FSM, the rotating search pointer and the sel / hold_cnt
// registers; the one-hot grant is the registered busy/sel decoded by
// DMux8Way, so no combinational path exists from req to grant.
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int HOLD_MAX = HOLD_MAX_DEFAULT  // legal range 1..8
) (
    input  logic         clk,
    input  logic         reset,
    rr_arbiter8_if.slave arb
);

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

    // Registered state
    state_t     r_state;
    logic [2:0] r_sel;
    logic [2:0] r_ptr;
    logic [3:0] r_hold;

    // Next-state values
    state_t     w_nxt_state;
    logic [2:0] w_nxt_sel;
    logic [2:0] w_nxt_ptr;
    logic [3:0] w_nxt_hold;

    // Decision terms
    logic [2:0] w_sel_inc;
    logic       w_owning;
    logic       w_owner_req;
    logic       w_others;
    logic       w_at_limit;
    logic       w_end;
    logic [2:0] w_pick_start;
    logic       w_found;
    logic [2:0] w_idx;
    logic       w_busy;

    assign w_sel_inc   = r_sel + 3'd1;
    assign w_owning    = (r_state == ST_OWN);
    assign w_owner_req = arb.req[r_sel];
    assign w_others    = |(arb.req & ~onehot8(r_sel));
    assign w_at_limit  = (r_hold == HOLD_LAST);

    // Ownership ends when the owner lets go, or when its hold time is used
    // up and somebody else is waiting. A sole requester keeps the resource.
    assign w_end = w_owning && (!w_owner_req || (w_at_limit && w_others));

    // While idle, search from the rotating pointer. While owning, the
    // search only matters at a handoff: it starts just after the owner and
    // skips the owner, so the owner is ranked last.
    assign w_pick_start = w_owning ? w_sel_inc : r_ptr;

    rr_pick8 u_pick (
        .i_req        (arb.req),
        .i_start      (w_pick_start),
        .i_exclude_en (w_owning),
        .i_exclude    (r_sel),
        .o_found      (w_found),
        .o_idx        (w_idx)
    );

    // Next-state and register-update decisions for the ownership FSM.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_sel   = r_sel;
        w_nxt_ptr   = r_ptr;
        w_nxt_hold  = r_hold;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_nxt_state = ST_OWN;
                    w_nxt_sel   = w_idx;
                    w_nxt_hold  = 4'd0;
                end
            end
            ST_OWN: begin
                if (w_end) begin
                    w_nxt_ptr = w_sel_inc;
                    if (w_found) begin
                        // Back-to-back handoff, no idle bubble.
                        w_nxt_sel  = w_idx;
                        w_nxt_hold = 4'd0;
                    end else begin
                        w_nxt_state = ST_IDLE;
                        w_nxt_hold  = 4'd0;
                    end
                end else if (!w_at_limit) begin
                    // Saturate at the limit for a sole requester.
                    w_nxt_hold = r_hold + 4'd1;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset drops any current owner.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_sel   <= 3'd0;
            r_ptr   <= 3'd0;
            r_hold  <= 4'd0;
        end else begin
            r_state <= w_nxt_state;
            r_sel   <= w_nxt_sel;
            r_ptr   <= w_nxt_ptr;
            r_hold  <= w_nxt_hold;
        end
    end

    assign w_busy = w_owning;

    // The grant is the demux of busy onto the selected line.
    DMux8Way u_dmux (
        .i_in  (w_busy),
        .i_sel (r_sel),
        .o_out (arb.grant)
    );

    assign arb.sel      = r_sel;
    assign arb.busy     = w_busy;
    assign arb.hold_cnt = r_hold;
    assign arb.state    = r_state;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed scenarios plus a randomized run, all
// checked against an ownership-level model of the round-robin rules.
module tb_rr_arbiter8;

  localparam int HM = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  // Model: who owns the resource and for how many cycles so far.
  int m_owner = -1;   // -1 means nobody
  int m_ptr = 0;
  int m_held = 0;
  int m_sel = 0;

  logic [2:0] exp_q[$];

  rr_arbiter8_if arb();

  rr_arbiter8 #(.HOLD_MAX(HM)) dut (
    .clk   (clk),
    .reset (reset),
    .arb   (arb)
  );

  always #5 clk = ~clk;

  // First requester in rotating order from start, skipping excl.
  function automatic int pick(input logic [7:0] r, input int start, input int excl);
    for (int k = 0; k < 8; k++) begin
      int n;
      n = (start + k) % 8;
      if (r[n] && n != excl) return n;
    end
    return -1;
  endfunction

  // Advance the model by one clock edge.
  function void model_step(input logic [7:0] r, input logic rst);
    int n;
    bit others;
    if (rst) begin
      m_owner = -1;
      m_ptr = 0;
      m_held = 0;
      m_sel = 0;
    end else if (m_owner < 0) begin
      n = pick(r, m_ptr, -1);
      if (n >= 0) begin
        m_owner = n;
        m_sel = n;
        m_held = 1;
      end
    end else begin
      others = (r & ~(8'h01 << m_owner)) != 8'h00;
      if (!r[m_owner] || (m_held >= HM && others)) begin
        m_ptr = (m_owner + 1) % 8;
        n = pick(r, m_ptr, m_owner);
        if (n >= 0) begin
          m_owner = n;
          m_sel = n;
          m_held = 1;
        end else begin
          m_owner = -1;
          m_held = 0;
        end
      end else begin
        m_held++;
      end
    end
  endfunction

  // Expected {grant, sel, busy, hold_cnt}; hold_cnt is don't-care when idle.
  function automatic logic [15:0] exp_vec();
    logic [7:0] g;
    logic [3:0] h;
    g = (m_owner >= 0) ? 8'(8'h01 << m_owner) : 8'h00;
    h = (m_owner >= 0) ? 4'(((m_held > HM) ? HM : m_held) - 1) : 4'd0;
    return {g, 3'(m_sel), (m_owner >= 0), h};
  endfunction

  function automatic logic [15:0] act_vec();
    return {arb.grant, arb.sel, arb.busy, (arb.busy ? arb.hold_cnt : 4'd0)};
  endfunction

  // Drive one cycle: inputs set after the previous edge, outputs sampled #1
  // after this edge.
  task automatic step(input logic [7:0] r, input logic rst);
    arb.req = r;
    reset = rst;
    @(posedge clk);
    model_step(r, rst);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(8'hFF, 1'b1);
      checks++;
      if (act_vec() !== 16'h0000 || arb.hold_cnt !== 4'd0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d actual=%h/%h required=0000/0", cyc, act_vec(), arb.hold_cnt);
      end
    end
    step(8'hFF, 1'b0);
    checks++;
    if (arb.grant !== 8'h01) begin
      failures++;
      $display("FAIL reset_release cyc=%0d grant=%h required=01", cyc, arb.grant);
    end
  endtask

  task automatic test_single();
    step(8'h00, 1'b1);
    step(8'h04, 1'b0);
    checks++;
    if (arb.grant !== 8'h04 || arb.sel !== 3'd2 || arb.busy !== 1'b1) begin
      failures++;
      $display("FAIL single_grant cyc=%0d grant=%h sel=%0d busy=%b required=04/2/1", cyc, arb.grant, arb.sel, arb.busy);
    end
    for (int i = 0; i < 3; i++) begin
      step(8'h04, 1'b0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL single_model cyc=%0d actual=%h required=%h", cyc, act_vec(), exp_vec());
      end
    end
    step(8'h00, 1'b0);
    checks++;
    if (arb.grant !== 8'h00 || arb.busy !== 1'b0) begin
      failures++;
      $display("FAIL single_release cyc=%0d grant=%h busy=%b required=00/0", cyc, arb.grant, arb.busy);
    end
  endtask

  task automatic test_contention();
    logic [2:0] e;
    step(8'h00, 1'b1);
    for (int c = 0; c < 40; c++) exp_q.push_back(3'((c / HM) % 8));
    for (int c = 0; c < 40; c++) begin
      step(8'hFF, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (arb.sel !== e || arb.busy !== 1'b1 || arb.grant !== (8'h01 << e)) begin
        failures++;
        $display("FAIL contention cyc=%0d sel=%0d busy=%b grant=%h required sel=%0d busy=1", cyc, arb.sel, arb.busy, arb.grant, e);
      end
    end
  endtask

  task automatic test_sole();
    step(8'h00, 1'b1);
    for (int c = 0; c < 12; c++) begin
      step(8'h20, 1'b0);
      checks++;
      if (arb.grant !== 8'h20 || arb.sel !== 3'd5 || arb.hold_cnt !== 4'((c < HM - 1) ? c : HM - 1)) begin
        failures++;
        $display("FAIL sole cyc=%0d grant=%h sel=%0d hold=%0d required 20/5/%0d", cyc, arb.grant, arb.sel, arb.hold_cnt, (c < HM - 1) ? c : HM - 1);
      end
    end
  endtask

  task automatic test_early_release();
    step(8'h00, 1'b1);
    step(8'h48, 1'b0);
    checks++;
    if (arb.sel !== 3'd3 || arb.grant !== 8'h08) begin
      failures++;
      $display("FAIL early_owner cyc=%0d sel=%0d grant=%h required 3/08", cyc, arb.sel, arb.grant);
    end
    step(8'h40, 1'b0);
    checks++;
    if (arb.grant !== 8'h40 || arb.sel !== 3'd6 || arb.hold_cnt !== 4'd0) begin
      failures++;
      $display("FAIL early_handoff cyc=%0d grant=%h sel=%0d hold=%0d required 40/6/0", cyc, arb.grant, arb.sel, arb.hold_cnt);
    end
  endtask

  task automatic test_reset_mid();
    step(8'h00, 1'b1);
    step(8'h20, 1'b0);
    step(8'hFF, 1'b0);
    checks++;
    if (arb.sel !== 3'd5 || arb.busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_owner cyc=%0d sel=%0d busy=%b required 5/1", cyc, arb.sel, arb.busy);
    end
    step(8'hFF, 1'b1);
    checks++;
    if (arb.grant !== 8'h00 || arb.sel !== 3'd0 || arb.busy !== 1'b0 || arb.hold_cnt !== 4'd0) begin
      failures++;
      $display("FAIL mid_reset cyc=%0d grant=%h sel=%0d busy=%b hold=%0d required 00/0/0/0", cyc, arb.grant, arb.sel, arb.busy, arb.hold_cnt);
    end
    step(8'hFF, 1'b0);
    checks++;
    if (arb.grant !== 8'h01) begin
      failures++;
      $display("FAIL mid_restart cyc=%0d grant=%h required 01", cyc, arb.grant);
    end
  endtask

  task automatic test_random();
    logic [7:0] r;
    logic rst;
    r = 8'h00;
    step(8'h00, 1'b1);
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      end
      rst = ($urandom_range(0, 79) == 0);
      step(r, rst);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random_model cyc=%0d req=%h actual=%h required=%h", cyc, r, act_vec(), exp_vec());
      end
      checks++;
      if ($countones(arb.grant) > 1) begin
        failures++;
        $display("FAIL random_onehot cyc=%0d grant=%h required at most one bit", cyc, arb.grant);
      end
    end
  endtask

  initial begin
    arb.req = 8'h00;
    test_reset();
    test_single();
    test_contention();
    test_sole();
    test_early_release();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
